// File: rtl/multicycle_adder_unit_if.sv
// Board-side bundle for the multicycle adder: buttons/switches in, display values out.
interface multicycle_adder_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SW_W  = 16
);

    // Active-low buttons and switch inputs
    logic             LoadA;
    logic             LoadB;
    logic             Run;
    logic             HiSel;
    logic [1:0]       Mode;
    logic [SW_W-1:0]  SW;

    // Display / status outputs
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [WIDTH-1:0] Sum;
    logic             CO;
    logic             Busy;
    logic             Done;

    // Board top level / testbench side
    modport master (
        output LoadA, LoadB, Run, HiSel, Mode, SW,
        input  OpA, OpB, Sum, CO, Busy, Done
    );

    // Adder unit side
    modport slave (
        input  LoadA, LoadB, Run, HiSel, Mode, SW,
        output OpA, OpB, Sum, CO, Busy, Done
    );

endinterface

// File: rtl/multicycle_adder_unit.sv
// Multicycle adder/subtractor: operands loaded in switch-width halves,
// result computed CHUNK bits per cycle through a registered carry.
module multicycle_adder_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8,
    parameter int unsigned SW_W  = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    multicycle_adder_unit_if.slave bus
);

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned OFF_W  = $clog2(WIDTH) + 1;
    localparam int unsigned CW     = CHUNK + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
    localparam logic [1:0]       MODE_SUB = 2'b01;
    localparam logic [1:0]       MODE_ACC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Architectural operand registers (live on the display)
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;

    // Per-operation snapshot and working state
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_work;
    logic             carry;
    logic [IDX_W-1:0] slice_idx;
    logic [1:0]       mode_lat;
    logic             run_prev;

    // Registered results and status
    logic [WIDTH-1:0] sum_reg;
    logic             co_reg;
    logic             busy_reg;
    logic             done_reg;

    // Combinational control and datapath
    logic             start_c;
    logic             last_slice_c;
    logic             load_a_c;
    logic             load_b_c;
    logic             calc_c;
    logic             commit_c;
    logic             acc_wb_c;
    logic             busy_next_c;
    logic             done_next_c;
    logic             sub_c;
    logic [OFF_W-1:0] slice_off_c;
    logic [CHUNK-1:0] slice_a_c;
    logic [CHUNK-1:0] slice_b_c;
    logic [CHUNK-1:0] slice_sum_c;
    logic             slice_co_c;
    logic [CW-1:0]    slice_ext_c;

    // A start is a press edge of the active-low Run button seen in IDLE
    assign start_c      = (state == ST_IDLE) && !bus.Run && run_prev;
    assign last_slice_c = (slice_idx == LAST_IDX);
    assign sub_c        = (bus.Mode == MODE_SUB);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_c)      state_next = ST_CALC;
            ST_CALC: if (last_slice_c) state_next = ST_DONE;
            ST_DONE:                   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Output/control decode from current and next state
    always_comb begin
        load_a_c    = 1'b0;
        load_b_c    = 1'b0;
        calc_c      = 1'b0;
        commit_c    = 1'b0;
        acc_wb_c    = 1'b0;
        busy_next_c = 1'b0;
        done_next_c = 1'b0;
        case (state)
            ST_IDLE: begin
                load_a_c = !bus.LoadA;
                load_b_c = bus.LoadA && !bus.LoadB;
            end
            ST_CALC: calc_c = 1'b1;
            ST_DONE: begin
                commit_c = 1'b1;
                acc_wb_c = (mode_lat == MODE_ACC);
            end
            default: ;
        endcase
        busy_next_c = (state_next == ST_CALC) || (state_next == ST_DONE);
        done_next_c = (state_next == ST_DONE);
    end

    // One CHUNK-wide slice of the ripple through the registered carry
    always_comb begin
        slice_off_c = OFF_W'(slice_idx) * OFF_W'(CHUNK);
        slice_a_c   = op_a[slice_off_c +: CHUNK];
        slice_b_c   = op_b[slice_off_c +: CHUNK];
        slice_ext_c = {1'b0, slice_a_c} + {1'b0, slice_b_c} + CW'(carry);
        slice_sum_c = slice_ext_c[CHUNK-1:0];
        slice_co_c  = slice_ext_c[CHUNK];
    end

    // Run edge tracking; keeps following Run even while busy
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_prev <= 1'b1;
        end else begin
            run_prev <= bus.Run;
        end
    end

    // Operand A: half loads in IDLE, write-back of the result in accumulate mode
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            reg_a <= '0;
        end else if (load_a_c) begin
            if (bus.HiSel) begin
                reg_a[WIDTH-1:SW_W] <= bus.SW;
            end else begin
                reg_a[SW_W-1:0] <= bus.SW;
            end
        end else if (acc_wb_c) begin
            reg_a <= sum_work;
        end
    end

    // Operand B: half loads in IDLE only
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            reg_b <= '0;
        end else if (load_b_c) begin
            if (bus.HiSel) begin
                reg_b[WIDTH-1:SW_W] <= bus.SW;
            end else begin
                reg_b[SW_W-1:0] <= bus.SW;
            end
        end
    end

    // Snapshot at start (subtract as A + ~B + 1), then one slice per CALC cycle
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            mode_lat  <= 2'b00;
            slice_idx <= '0;
            sum_work  <= '0;
        end else if (start_c) begin
            op_a      <= reg_a;
            op_b      <= sub_c ? ~reg_b : reg_b;
            carry     <= sub_c;
            mode_lat  <= bus.Mode;
            slice_idx <= '0;
        end else if (calc_c) begin
            sum_work[slice_off_c +: CHUNK] <= slice_sum_c;
            carry     <= slice_co_c;
            slice_idx <= slice_idx + IDX_W'(1);
        end
    end

    // Result registers update only when an operation completes
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sum_reg <= '0;
            co_reg  <= 1'b0;
        end else if (commit_c) begin
            sum_reg <= sum_work;
            co_reg  <= carry;
        end
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next_c;
            done_reg <= done_next_c;
        end
    end

    assign bus.OpA  = reg_a;
    assign bus.OpB  = reg_b;
    assign bus.Sum  = sum_reg;
    assign bus.CO   = co_reg;
    assign bus.Busy = busy_reg;
    assign bus.Done = done_reg;

endmodule

// File: tb/tb_multicycle_adder_unit.sv
// Randomized self-checking bench for multicycle_adder_unit against an arithmetic model.
module tb_multicycle_adder_unit;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned SW_W   = 16;
    localparam int unsigned NSLICE = WIDTH / CHUNK;

    logic Clk = 1'b0;
    logic Reset;

    multicycle_adder_unit_if #(.WIDTH(WIDTH), .SW_W(SW_W)) bus ();

    multicycle_adder_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SW_W(SW_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the operand registers as the user sees them
    logic [WIDTH-1:0] model_a;
    logic [WIDTH-1:0] model_b;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input bit to_b, input bit hi, input logic [SW_W-1:0] val);
        bus.HiSel = hi;
        bus.SW    = val;
        if (to_b) bus.LoadB = 1'b0;
        else      bus.LoadA = 1'b0;
        tick();
        bus.LoadA = 1'b1;
        bus.LoadB = 1'b1;
        if (to_b) begin
            if (hi) model_b[WIDTH-1:SW_W] = val;
            else    model_b[SW_W-1:0]     = val;
        end else begin
            if (hi) model_a[WIDTH-1:SW_W] = val;
            else    model_a[SW_W-1:0]     = val;
        end
    endtask

    task automatic set_operands(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        do_load(1'b0, 1'b0, a[SW_W-1:0]);
        do_load(1'b0, 1'b1, a[WIDTH-1:SW_W]);
        do_load(1'b1, 1'b0, b[SW_W-1:0]);
        do_load(1'b1, 1'b1, b[WIDTH-1:SW_W]);
        checks++;
        if (bus.OpA !== a) begin
            errors++;
            $display("FAIL load_a: got %h expected %h", bus.OpA, a);
        end
        checks++;
        if (bus.OpB !== b) begin
            errors++;
            $display("FAIL load_b: got %h expected %h", bus.OpB, b);
        end
    endtask

    // Press Run once (optionally with a same-cycle load of A) and check timing and result
    task automatic run_op(input string name, input logic [1:0] mode, input bit with_load,
                          input bit hi, input logic [SW_W-1:0] sw_val,
                          output logic [WIDTH-1:0] exp_sum, output logic exp_co);
        logic [WIDTH:0] wide;
        if (mode == 2'b01) begin
            exp_sum = model_a - model_b;
            exp_co  = (model_a >= model_b);
        end else begin
            wide    = {1'b0, model_a} + {1'b0, model_b};
            exp_sum = wide[WIDTH-1:0];
            exp_co  = wide[WIDTH];
        end
        bus.Mode = mode;
        bus.Run  = 1'b0;
        if (with_load) begin
            bus.LoadA = 1'b0;
            bus.HiSel = hi;
            bus.SW    = sw_val;
        end
        tick();
        bus.Run   = 1'b1;
        bus.LoadA = 1'b1;
        bus.Mode  = 2'($urandom);
        if (with_load) begin
            if (hi) model_a[WIDTH-1:SW_W] = sw_val;
            else    model_a[SW_W-1:0]     = sw_val;
        end
        if (mode == 2'b10) model_a = exp_sum;
        for (int k = 1; k <= int'(NSLICE) + 1; k++) begin
            checks++;
            if (bus.Busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, k, bus.Busy);
            end
            checks++;
            if (bus.Done !== (k == int'(NSLICE) + 1)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, k, bus.Done,
                         (k == int'(NSLICE) + 1));
            end
            tick();
        end
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after done: got done=%b busy=%b expected 0 0", name, bus.Done, bus.Busy);
        end
        checks++;
        if (bus.Sum !== exp_sum) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, bus.Sum, exp_sum);
        end
        checks++;
        if (bus.CO !== exp_co) begin
            errors++;
            $display("FAIL %s co: got %b expected %b", name, bus.CO, exp_co);
        end
        checks++;
        if (bus.OpA !== model_a || bus.OpB !== model_b) begin
            errors++;
            $display("FAIL %s operands: got %h/%h expected %h/%h", name, bus.OpA, bus.OpB,
                     model_a, model_b);
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b0;
        bus.LoadA = 1'b1;
        bus.LoadB = 1'b1;
        bus.Run   = 1'b1;
        bus.HiSel = 1'b0;
        bus.Mode  = 2'b00;
        bus.SW    = '0;
        tick();
        tick();
        checks++;
        if (bus.OpA !== '0 || bus.OpB !== '0 || bus.Sum !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h/%h expected 0", bus.OpA, bus.OpB, bus.Sum);
        end
        checks++;
        if (bus.CO !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got co=%b busy=%b done=%b expected 0", bus.CO, bus.Busy, bus.Done);
        end
        Reset   = 1'b1;
        model_a = '0;
        model_b = '0;
        tick();
    endtask

    task automatic test_add_carry();
        logic [WIDTH-1:0] s;
        logic             c;
        set_operands(32'hFFFF_FFFF, 32'h0000_0001);
        run_op("add_carry", 2'b00, 1'b0, 1'b0, '0, s, c);
        checks++;
        if (bus.Sum !== 32'h0 || bus.CO !== 1'b1) begin
            errors++;
            $display("FAIL add_carry_const: got %h/%b expected 00000000/1", bus.Sum, bus.CO);
        end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] s;
        logic             c;
        set_operands(32'd5, 32'd7);
        run_op("sub_borrow", 2'b01, 1'b0, 1'b0, '0, s, c);
        checks++;
        if (bus.Sum !== 32'hFFFF_FFFE || bus.CO !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow_const: got %h/%b expected fffffffe/0", bus.Sum, bus.CO);
        end
        set_operands(32'd7, 32'd5);
        run_op("sub_pos", 2'b01, 1'b0, 1'b0, '0, s, c);
        checks++;
        if (bus.Sum !== 32'd2 || bus.CO !== 1'b1) begin
            errors++;
            $display("FAIL sub_pos_const: got %h/%b expected 00000002/1", bus.Sum, bus.CO);
        end
    endtask

    task automatic test_accumulate();
        logic [WIDTH-1:0] s;
        logic             c;
        logic [WIDTH-1:0] expect_vals [3] = '{32'd4, 32'd7, 32'd10};
        set_operands(32'd1, 32'd3);
        for (int i = 0; i < 3; i++) begin
            run_op("accumulate", 2'b10, 1'b0, 1'b0, '0, s, c);
            checks++;
            if (bus.Sum !== expect_vals[i] || bus.OpA !== expect_vals[i] || bus.CO !== 1'b0) begin
                errors++;
                $display("FAIL accumulate_%0d: got sum=%h opa=%h co=%b expected %h/%h/0", i,
                         bus.Sum, bus.OpA, bus.CO, expect_vals[i], expect_vals[i]);
            end
        end
    endtask

    task automatic test_hold_run();
        logic [WIDTH-1:0] exp_sum;
        logic [WIDTH:0]   wide;
        int               dones = 0;
        set_operands($urandom, $urandom);
        wide      = {1'b0, model_a} + {1'b0, model_b};
        exp_sum   = wide[WIDTH-1:0];
        bus.Mode  = 2'b00;
        bus.Run   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.Done === 1'b1) dones++;
            if (i == 1) begin
                bus.LoadA = 1'b0;
                bus.HiSel = 1'b0;
                bus.SW    = ~model_a[SW_W-1:0];
            end else begin
                bus.LoadA = 1'b1;
            end
        end
        bus.Run = 1'b1;
        tick();
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL hold_run_dones: got %0d expected 1", dones);
        end
        checks++;
        if (bus.OpA !== model_a) begin
            errors++;
            $display("FAIL load_in_calc: got %h expected %h", bus.OpA, model_a);
        end
        checks++;
        if (bus.Sum !== exp_sum || bus.CO !== wide[WIDTH]) begin
            errors++;
            $display("FAIL hold_run_result: got %h/%b expected %h/%b", bus.Sum, bus.CO, exp_sum, wide[WIDTH]);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        set_operands(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.Mode = 2'b00;
        bus.Run  = 1'b0;
        tick();
        bus.Run = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        Reset   = 1'b1;
        model_a = '0;
        model_b = '0;
        checks++;
        if (bus.Sum !== '0 || bus.CO !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got sum=%h co=%b busy=%b done=%b expected 0", bus.Sum, bus.CO,
                     bus.Busy, bus.Done);
        end
        checks++;
        if (bus.OpA !== '0 || bus.OpB !== '0) begin
            errors++;
            $display("FAIL reset_mid_ops: got %h/%h expected 0", bus.OpA, bus.OpB);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid_after: got %0d active cycles expected 0", dones);
        end
    endtask

    task automatic test_both_loads();
        set_operands(32'h1234_5678, 32'h9ABC_DEF0);
        bus.LoadA = 1'b0;
        bus.LoadB = 1'b0;
        bus.HiSel = 1'b1;
        bus.SW    = 16'hABCD;
        tick();
        bus.LoadA = 1'b1;
        bus.LoadB = 1'b1;
        model_a[WIDTH-1:SW_W] = 16'hABCD;
        checks++;
        if (bus.OpA !== 32'hABCD_5678 || bus.OpB !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL both_loads: got %h/%h expected abcd5678/9abcdef0", bus.OpA, bus.OpB);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = ~a;
            if (i % 8 == 1) b = a;
            set_operands(a, b);
            run_op("random", 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   1'($urandom), 16'($urandom), s, c);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_accumulate();
        test_hold_run();
        test_reset_mid();
        test_both_loads();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
